dmem_dump_unit: RTL

DMEM_DUMP_UNIT -- requirements
Module: dmem_dump_unit

---
 rtl/dmem_dump_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_dump_unit.sv
// Data memory with a handshaked dump port.
// Normal processor loads are combinational and stores are synchronous. A rising edge on
// dump, seen while idle, streams every word out as (byte address, data) beats on a
// valid/ready handshake. A one-cycle dump_done pulse follows the last accepted beat.
module dmem_dump_unit #(
    parameter int unsigned N     = 64,
    parameter int unsigned DEPTH = 32
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    output logic [N-1:0] DM_readData,
    input  logic         dump,
    input  logic         dump_ready,
    output logic         dump_valid,
    output logic [N-1:0] dump_addr,
    output logic [N-1:0] dump_data,
    output logic         dump_busy,
    output logic         dump_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StDone
    } state_e;

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] widx;
    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          dump_q;
    logic [N-1:0]  dump_addr_q, dump_data_q;
    logic          capture;
    logic          unused_addr_bits;

    // Byte-offset bits and bits above the index are ignored, so the memory aliases.
    assign widx             = DM_addr[AW+2:3];
    assign unused_addr_bits = ^{DM_addr[N-1:AW+3], DM_addr[2:0]};
    assign DM_readData      = mem_q[widx];

    // Memory array: cleared on reset, and written in every FSM state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (DM_writeEnable) begin
            mem_q[widx] <= DM_writeData;
        end
    end

    // FSM next state. LOAD captures the word, and SEND waits for the sink.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dump && !dump_q) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                capture = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (dump_ready) begin
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state, the dump edge detector and the beat registers. A store on the capture
    // edge does not reach dump_data, because the capture reads the old memory contents.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            dump_q      <= 1'b0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dump_q  <= dump;
            if (capture) begin
                dump_addr_q <= N'({idx_q, 3'b000});
                dump_data_q <= mem_q[idx_q];
            end
        end
    end

    // Status outputs are decoded from the state register, so reset forces them low.
    always_comb begin
        dump_valid = (state_q == StSend);
        dump_busy  = (state_q != StIdle);
        dump_done  = (state_q == StDone);
        dump_addr  = dump_addr_q;
        dump_data  = dump_data_q;
    end

endmodule
